async_fifo_gray: RTL and testbench

Parametrised dual-clock FIFO, the successor to the team's basic asynchronous FIFO. Uses Gray-coded pointers with 2-flop synchronisers for correct clock-domain crossing. Adds fill levels, programmable almost-full/almost-empty flags, sticky overflow/underflow errors and registered read data with a valid strobe. It sits between any write-clock producer and read-clock consumer, for example a stream bridge or a packet buffer.

---
 rtl/async_fifo_pkg.sv | 38 +++
 rtl/async_fifo_sync2.sv | 38 +++
 rtl/async_fifo_gray.sv | 227 ++++++++++++++++++++++
 tb/tb_async_fifo_gray.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
//
// Shared definitions for the Gray-pointer dual-clock FIFO:
//   - default data width and depth used by async_fifo_gray
//   - bin2gray / gray2bin conversion helpers
//
// The helpers work on a fixed GRAY_W-bit container so any pointer width up to
// GRAY_W can use them. Callers zero-extend the pointer on the way in and
// truncate back to PTR_WIDTH+1 bits on the way out. Leading zeros do not
// affect either conversion, so the truncated result is exact.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Widest pointer the conversion helpers can handle.
    localparam int GRAY_W = 32;

    // Binary to reflected Gray code: each bit is the XOR of itself and the
    // next more-significant bit.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above its position, computed as a running XOR from the MSB down.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_sync2.sv
// -----------------------------------------------------------------------------
// async_fifo_sync2
//
// Generic N-bit two-flop synchroniser with synchronous, active-high reset.
// Used for the Gray pointers crossing between the FIFO clock domains and for
// carrying the reset into the read domain. Only Gray-coded buses (at most one
// bit changing per source clock) or single bits may be passed through it.
//
// Ports:
//   clk  in   destination-domain clock
//   rst  in   synchronous reset in the destination domain, clears both stages
//   d    in   N-bit asynchronous input
//   q    out  N-bit synchronised output, two clk edges behind d
// -----------------------------------------------------------------------------
module async_fifo_sync2 #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta;

    // First stage may go metastable; the second stage gives it a full clock
    // period to resolve before anything downstream looks at the value.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_fifo_gray.sv
// -----------------------------------------------------------------------------
// async_fifo_gray
//
// Dual-clock FIFO with Gray-coded pointers and two-flop synchronisers.
// Provides registered full/empty, fill levels on both sides, programmable
// almost-full/almost-empty flags, sticky overflow/underflow errors and a
// registered read-data output with a one-cycle valid strobe.
//
// Ports (write domain, wr_clk):
//   wr_clk       in   write clock
//   rst          in   synchronous active-high reset, sampled on wr_clk
//   wr_en        in   write request
//   wdata        in   write data [WIDTH]
//   full         out  FIFO full, registered
//   almost_full  out  wr_level >= AFULL_TH, registered
//   wr_level     out  occupancy seen by the writer [PTR_WIDTH+1]
//   wr_overflow  out  sticky: write attempted while full
// Ports (read domain, rd_clk):
//   rd_clk       in   read clock
//   rd_en        in   read request
//   rdata        out  read data, registered [WIDTH]
//   rd_valid     out  one-cycle pulse when rdata has been updated
//   empty        out  FIFO empty, registered
//   almost_empty out  rd_level <= AEMPTY_TH, registered
//   rd_level     out  occupancy seen by the reader [PTR_WIDTH+1]
//   rd_underflow out  sticky: read attempted while empty
//
// Pointers are PTR_WIDTH+1 bits wide; the extra MSB distinguishes full from
// empty when the address bits match. Only the registered Gray copies of the
// pointers cross between domains. The reset reaches the read domain through
// its own synchroniser, so the read side comes out of reset two rd_clk edges
// after rst falls and reports empty until then.
// -----------------------------------------------------------------------------
module async_fifo_gray
    import async_fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                 wr_clk,
    input  logic                 rd_clk,
    input  logic                 rst,

    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 wr_overflow,

    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_level,
    output logic                 rd_underflow
);

    localparam int PW = PTR_WIDTH + 1;

    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_TH);

    // Storage is not reset; stale entries are unreachable once the pointers
    // are cleared.
    logic [WIDTH-1:0] mem [DEPTH];

    // ---------------------------------------------------------------------
    // Write domain signals
    // ---------------------------------------------------------------------
    logic [PW-1:0] wptr;
    logic [PW-1:0] wgray;
    logic [PW-1:0] wptr_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rgray_ws;
    logic [PW-1:0] rbin_ws;
    logic [PW-1:0] wr_level_next;
    logic          wr_accept;
    logic          full_next;

    // ---------------------------------------------------------------------
    // Read domain signals
    // ---------------------------------------------------------------------
    logic          rd_rst;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rgray;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wgray_rs;
    logic [PW-1:0] wbin_rs;
    logic [PW-1:0] rd_level_next;
    logic          rd_accept;
    logic          empty_next;

    // ---------------------------------------------------------------------
    // Clock-domain crossings
    // ---------------------------------------------------------------------

    // The reset synchroniser has no reset of its own: it must keep passing
    // rst through while the read side is being held in reset.
    async_fifo_sync2 #(.N(1)) u_rst_sync (
        .clk (rd_clk),
        .rst (1'b0),
        .d   (rst),
        .q   (rd_rst)
    );

    async_fifo_sync2 #(.N(PW)) u_wgray_sync (
        .clk (rd_clk),
        .rst (rd_rst),
        .d   (wgray),
        .q   (wgray_rs)
    );

    async_fifo_sync2 #(.N(PW)) u_rgray_sync (
        .clk (wr_clk),
        .rst (rst),
        .d   (rgray),
        .q   (rgray_ws)
    );

    // ---------------------------------------------------------------------
    // Write side next-state logic
    // ---------------------------------------------------------------------

    // Full compares the post-write Gray pointer with the synchronised read
    // pointer having its two MSBs inverted: in Gray code that is the
    // pattern of a pointer exactly DEPTH entries ahead. Because rgray_ws
    // lags the real read pointer, full can only be late to clear, never
    // early, and the level can only over-report.
    always_comb begin
        wr_accept     = wr_en && !full && !rst;
        wptr_next     = wr_accept ? (wptr + PTR_ONE) : wptr;
        wgray_next    = PW'(bin2gray(GRAY_W'(wptr_next)));
        rbin_ws       = PW'(gray2bin(GRAY_W'(rgray_ws)));
        full_next     = (wgray_next == {~rgray_ws[PW-1:PW-2], rgray_ws[PW-3:0]});
        wr_level_next = wptr_next - rbin_ws;
    end

    // ---------------------------------------------------------------------
    // Write side registers
    // ---------------------------------------------------------------------

    // Flags and level are registered from the next-state values so full
    // rises on the same edge that accepts the last free entry.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wptr        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            wr_overflow <= 1'b0;
        end else begin
            wptr        <= wptr_next;
            wgray       <= wgray_next;
            full        <= full_next;
            wr_level    <= wr_level_next;
            almost_full <= (wr_level_next >= AFULL_LVL);
            if (wr_en && full) begin
                wr_overflow <= 1'b1;
            end
        end
    end

    // Memory write port; rejected writes and writes during reset never
    // touch the array.
    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem[wptr[PTR_WIDTH-1:0]] <= wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Read side next-state logic
    // ---------------------------------------------------------------------

    // Empty is a straight Gray equality against the synchronised write
    // pointer. wgray_rs lags the real write pointer, so empty can only be
    // late to clear, never early.
    always_comb begin
        rd_accept     = rd_en && !empty;
        rptr_next     = rd_accept ? (rptr + PTR_ONE) : rptr;
        rgray_next    = PW'(bin2gray(GRAY_W'(rptr_next)));
        wbin_rs       = PW'(gray2bin(GRAY_W'(wgray_rs)));
        empty_next    = (rgray_next == wgray_rs);
        rd_level_next = wbin_rs - rptr_next;
    end

    // ---------------------------------------------------------------------
    // Read side registers
    // ---------------------------------------------------------------------

    // rdata holds its last value on an idle or rejected read so the
    // consumer can rely on rd_valid alone to know when it changed.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rptr         <= '0;
            rgray        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            rdata        <= '0;
            rd_valid     <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            rptr         <= rptr_next;
            rgray        <= rgray_next;
            empty        <= empty_next;
            rd_level     <= rd_level_next;
            almost_empty <= (rd_level_next <= AEMPTY_LVL);
            rd_valid     <= rd_accept;
            if (rd_accept) begin
                rdata <= mem[rptr[PTR_WIDTH-1:0]];
            end
            if (rd_en && empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_gray.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_gray
//
// Self-checking bench for async_fifo_gray (WIDTH=8, DEPTH=16).
// Every word the bench expects to come out of the FIFO is pushed into exp_q
// when it is written; an independent monitor pops and compares whenever
// rd_valid is seen. Directed sections check flags, levels, errors, reset and
// flag latency against hand-computed values.
// -----------------------------------------------------------------------------
module tb_async_fifo_gray;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int LW = 5;

    logic          wr_clk;
    logic          rd_clk;
    logic          rst;
    logic          wr_en;
    logic [W-1:0]  wdata;
    logic          full;
    logic          almost_full;
    logic [LW-1:0] wr_level;
    logic          wr_overflow;
    logic          rd_en;
    logic [W-1:0]  rdata;
    logic          rd_valid;
    logic          empty;
    logic          almost_empty;
    logic [LW-1:0] rd_level;
    logic          rd_underflow;

    int            checks    = 0;
    int            failures  = 0;
    int            rx_count  = 0;
    int            rd_lo     = 5;
    int            rd_hi     = 5;
    logic [W-1:0]  next_data = 8'h00;
    logic [W-1:0]  exp_q[$];

    async_fifo_gray dut (
        .wr_clk       (wr_clk),
        .rd_clk       (rd_clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .wr_overflow  (wr_overflow),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .rd_underflow (rd_underflow)
    );

    // Write clock: fixed 10-unit period.
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // Read clock: offset from wr_clk so edges never coincide; the low/high
    // halves are variables so the period can be changed mid-run.
    initial begin
        rd_clk = 1'b0;
        #2;
        forever begin
            #(rd_lo) rd_clk = 1'b1;
            #(rd_hi) rd_clk = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_latency(input string name, input int edges);
        checks++;
        if (edges < 2 || edges > 3) begin
            failures++;
            $display("[TB] FAIL %s edges=%0d expected 2..3", name, edges);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [W-1:0] d);
        wr_en = we;
        wdata = d;
    endtask

    task automatic wait_rd(input int n);
        repeat (n) @(negedge rd_clk);
    endtask

    // Writes n words from next_data upward, each cycle with probability
    // pct percent, only while the FIFO reports not full.
    task automatic write_stream(input int n, input int pct, input bit push);
        int sent = 0;
        int cyc = 0;
        bit timed_out = 1'b0;
        while (sent < n && !timed_out) begin
            @(negedge wr_clk);
            cyc++;
            if (cyc > 20000) begin
                timed_out = 1'b1;
                applyStimulus(1'b0, 8'h00);
            end else if (!full && (int'($urandom_range(99)) < pct)) begin
                applyStimulus(1'b1, next_data);
                if (push) exp_q.push_back(next_data);
                next_data = next_data + 8'd1;
                sent++;
            end else begin
                applyStimulus(1'b0, next_data);
            end
        end
        @(negedge wr_clk);
        applyStimulus(1'b0, 8'h00);
        checks++;
        if (timed_out) begin
            failures++;
            $display("[TB] FAIL write_stream_timeout actual=%0d expected=%0d", sent, n);
        end
    endtask

    // Reads n words, each cycle with probability pct percent, only while
    // the FIFO reports not empty.
    task automatic read_stream(input int n, input int pct);
        int got = 0;
        int cyc = 0;
        bit timed_out = 1'b0;
        while (got < n && !timed_out) begin
            @(negedge rd_clk);
            cyc++;
            if (cyc > 5000) begin
                timed_out = 1'b1;
                rd_en = 1'b0;
            end else if (!empty && (int'($urandom_range(99)) < pct)) begin
                rd_en = 1'b1;
                got++;
            end else begin
                rd_en = 1'b0;
            end
        end
        @(negedge rd_clk);
        rd_en = 1'b0;
        checks++;
        if (timed_out) begin
            failures++;
            $display("[TB] FAIL read_stream_timeout actual=%0d expected=%0d", got, n);
        end
    endtask

    // Monitor: every rd_valid pulse must deliver the oldest outstanding
    // expected word.
    initial begin
        logic [W-1:0] exp_word;
        forever begin
            @(posedge rd_clk);
            #1;
            if (rd_valid === 1'b1) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rdata_unexpected actual=0x%0h expected=none", rdata);
                end else begin
                    exp_word = exp_q.pop_front();
                    checkOutput("rdata_order", 32'(rdata), 32'(exp_word));
                end
            end
        end
    end

    initial begin
        int n;
        int rx0;

        rst   = 1'b1;
        rd_en = 1'b0;
        applyStimulus(1'b0, 8'h00);
        repeat (6) @(negedge wr_clk);
        rst = 1'b0;
        wait_rd(4);

        $display("[TB] reset values");
        checkOutput("rst_full",         32'(full),         32'd0);
        checkOutput("rst_almost_full",  32'(almost_full),  32'd0);
        checkOutput("rst_wr_level",     32'(wr_level),     32'd0);
        checkOutput("rst_wr_overflow",  32'(wr_overflow),  32'd0);
        checkOutput("rst_empty",        32'(empty),        32'd1);
        checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
        checkOutput("rst_rd_level",     32'(rd_level),     32'd0);
        checkOutput("rst_rdata",        32'(rdata),        32'd0);
        checkOutput("rst_rd_valid",     32'(rd_valid),     32'd0);
        checkOutput("rst_rd_underflow", 32'(rd_underflow), 32'd0);

        // Fill with 0x00..0x0F, then one rejected write of 0xAA.
        $display("[TB] fill to full and overflow");
        @(negedge wr_clk);
        applyStimulus(1'b1, 8'h00);
        exp_q.push_back(8'h00);
        for (int i = 0; i < D; i++) begin
            @(negedge wr_clk);
            checkOutput("fill_wr_level",    32'(wr_level),    32'(i + 1));
            checkOutput("fill_almost_full", 32'(almost_full), 32'((i + 1) >= 14));
            checkOutput("fill_full",        32'(full),        32'(i == D - 1));
            if (i < D - 1) begin
                applyStimulus(1'b1, 8'(i + 1));
                exp_q.push_back(8'(i + 1));
            end else begin
                applyStimulus(1'b1, 8'hAA);
            end
        end
        @(negedge wr_clk);
        applyStimulus(1'b0, 8'h00);
        checkOutput("ovf_wr_overflow", 32'(wr_overflow), 32'd1);
        checkOutput("ovf_full",        32'(full),        32'd1);
        checkOutput("ovf_wr_level",    32'(wr_level),    32'd16);

        wait_rd(5);
        checkOutput("full_rd_level",     32'(rd_level),     32'd16);
        checkOutput("full_empty",        32'(empty),        32'd0);
        checkOutput("full_almost_empty", 32'(almost_empty), 32'd0);

        // Drain all sixteen back-to-back, then one read from empty.
        $display("[TB] drain and underflow");
        @(negedge rd_clk);
        rd_en = 1'b1;
        for (int i = 0; i < D; i++) begin
            @(negedge rd_clk);
            checkOutput("drain_rd_valid",     32'(rd_valid),     32'd1);
            checkOutput("drain_rd_level",     32'(rd_level),     32'(D - 1 - i));
            checkOutput("drain_almost_empty", 32'(almost_empty), 32'((D - 1 - i) <= 2));
            checkOutput("drain_empty",        32'(empty),        32'(i == D - 1));
            if (i == D - 1) rd_en = 1'b0;
        end
        @(negedge rd_clk);
        rd_en = 1'b1;
        @(negedge rd_clk);
        rd_en = 1'b0;
        checkOutput("udf_rd_underflow", 32'(rd_underflow), 32'd1);
        checkOutput("udf_rd_valid",     32'(rd_valid),     32'd0);
        checkOutput("udf_rdata_held",   32'(rdata),        32'h0F);
        checkOutput("udf_empty",        32'(empty),        32'd1);

        // Empty-deassert latency after a single write.
        $display("[TB] flag latency");
        repeat (6) @(negedge wr_clk);
        checkOutput("idle_wr_level", 32'(wr_level), 32'd0);
        @(negedge wr_clk);
        applyStimulus(1'b1, 8'h3C);
        exp_q.push_back(8'h3C);
        @(posedge wr_clk);
        #1;
        applyStimulus(1'b0, 8'h00);
        n = 0;
        while (n < 10) begin
            @(posedge rd_clk);
            #1;
            n++;
            if (!empty) break;
        end
        check_latency("empty_fall_latency", n);
        read_stream(1, 100);
        wait_rd(6);

        // Full-deassert latency after a single read.
        next_data = 8'h80;
        write_stream(D, 100, 1'b1);
        checkOutput("refill_full",     32'(full),     32'd1);
        checkOutput("refill_wr_level", 32'(wr_level), 32'd16);
        wait_rd(5);
        @(negedge rd_clk);
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
        n = 0;
        while (n < 10) begin
            @(posedge wr_clk);
            #1;
            n++;
            if (!full) break;
        end
        check_latency("full_fall_latency", n);
        read_stream(D - 1, 100);
        wait_rd(6);

        // Stream three FIFO depths through a half-full FIFO so both pointers
        // wrap past their MSB.
        $display("[TB] wrap-around at half full");
        next_data = 8'h40;
        write_stream(8, 100, 1'b1);
        wait_rd(6);
        checkOutput("half_wr_level", 32'(wr_level), 32'd8);
        checkOutput("half_rd_level", 32'(rd_level), 32'd8);
        fork
            write_stream(3 * D, 100, 1'b1);
            read_stream(3 * D, 100);
        join
        wait_rd(6);
        checkOutput("wrap_wr_level", 32'(wr_level), 32'd8);
        checkOutput("wrap_rd_level", 32'(rd_level), 32'd8);
        read_stream(8, 100);
        wait_rd(6);
        checkOutput("wrap_drain_wr_level", 32'(wr_level), 32'd0);
        checkOutput("wrap_drain_rd_level", 32'(rd_level), 32'd0);
        checkOutput("wrap_drain_empty",    32'(empty),    32'd1);

        // Reset with nine entries held; writes attempted during reset.
        $display("[TB] reset mid-operation");
        next_data = 8'h90;
        write_stream(9, 100, 1'b0);
        wait_rd(6);
        checkOutput("pre_rst_rd_level", 32'(rd_level), 32'd9);
        checkOutput("pre_rst_wr_level", 32'(wr_level), 32'd9);
        @(negedge wr_clk);
        rst = 1'b1;
        applyStimulus(1'b1, 8'hEE);
        repeat (5) @(negedge wr_clk);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00);
        wait_rd(5);
        checkOutput("mid_rst_empty",        32'(empty),        32'd1);
        checkOutput("mid_rst_almost_empty", 32'(almost_empty), 32'd1);
        checkOutput("mid_rst_rd_level",     32'(rd_level),     32'd0);
        checkOutput("mid_rst_rd_underflow", 32'(rd_underflow), 32'd0);
        checkOutput("mid_rst_wr_overflow",  32'(wr_overflow),  32'd0);
        checkOutput("mid_rst_wr_level",     32'(wr_level),     32'd0);
        checkOutput("mid_rst_full",         32'(full),         32'd0);
        rx0 = rx_count;
        next_data = 8'h55;
        write_stream(1, 100, 1'b1);
        wait_rd(6);
        read_stream(1, 100);
        wait_rd(3);
        checkOutput("post_rst_rx_count", 32'(rx_count - rx0), 32'd1);
        checkOutput("post_rst_queue",    32'(exp_q.size()),   32'd0);

        // Random traffic, read clock period 37.
        $display("[TB] random traffic, slow read clock");
        rd_lo = 18;
        rd_hi = 19;
        wait_rd(2);
        rx0 = rx_count;
        next_data = 8'h00;
        fork
            write_stream(1000, 60, 1'b1);
            read_stream(1000, 60);
        join
        wait_rd(6);
        checkOutput("rand_rx_count",     32'(rx_count - rx0), 32'd1000);
        checkOutput("rand_queue",        32'(exp_q.size()),   32'd0);
        checkOutput("rand_wr_overflow",  32'(wr_overflow),    32'd0);
        checkOutput("rand_rd_underflow", 32'(rd_underflow),   32'd0);
        checkOutput("rand_empty",        32'(empty),          32'd1);
        checkOutput("rand_wr_level",     32'(wr_level),       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
